// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the instruction fetch path.
package prog_loader_pkg;

    // Instruction address and word widths, shared with the fetch path.
    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 32;

    // Loader FSM encoding.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/loader_lat_counter.sv
// Source read latency timer: 3-bit down-counter with terminal-count compare.
// Loaded with SRC_LAT-1 in the READ cycle; expired marks the last WAIT cycle.
module loader_lat_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       en,
    output logic       expired
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Next count: load has priority, otherwise count down while enabled.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != 3'd0)) begin
            count_d = count_q - 3'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == 3'd1);

endmodule

// File: rtl/prog_loader.sv
// Sequential copy engine that fills instruction memory from a fixed-latency source.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; address outputs hold their last values
// CHECK   | validate length and destination range of the latched request
// READ    | one-cycle source read strobe at the current source pointer
// WAIT    | waiting SRC_LAT-1 cycles for source data
// WRITE   | write the returned word to instruction memory, advance pointers
// DONE    | one-cycle done pulse (err as determined), then IDLE
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SRC_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] length,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] words_done
);

    localparam logic [2:0]      LAT_M1    = 3'(SRC_LAT - 1);
    localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              lat_load, lat_en, lat_expired;
    logic [ADDR_W:0]   dst_end;
    logic              dst_over;

    loader_lat_counter u_lat (
        .clock    (clock),
        .reset    (reset),
        .load     (lat_load),
        .load_val (LAT_M1),
        .en       (lat_en),
        .expired  (lat_expired)
    );

    // Destination end computed one bit wider so a range ending past the top is caught.
    assign dst_end  = {1'b0, dst_ptr_q} + {1'b0, len_q};
    assign dst_over = (dst_end > ADDR_SPAN);

    // FSM next state, pointer and counter updates.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        len_d     = len_q;
        words_d   = words_q;
        err_d     = err_q;
        lat_load  = 1'b0;
        lat_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d = src_base;
                    dst_ptr_d = dst_base;
                    len_d     = length;
                    words_d   = '0;
                    err_d     = 1'b0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort || ((len_q != '0) && dst_over)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (len_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (SRC_LAT > 1) begin
                    lat_load = 1'b1;
                    state_d  = S_WAIT;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WAIT: begin
                lat_en = 1'b1;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (lat_expired) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // The write in this cycle always lands, even when aborted.
                src_ptr_d = src_ptr_q + ADDR_W'(1);
                dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                words_d   = words_q + ADDR_W'(1);
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if ((words_q + ADDR_W'(1)) == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address outputs are registered copies of the pointers taken on entry to
    // READ/WRITE, so they hold the last used address rather than the advanced pointer.
    always_comb begin
        src_addr_d  = (state_d == S_READ)  ? src_ptr_d : src_addr_q;
        imem_addr_d = (state_d == S_WRITE) ? dst_ptr_d : imem_addr_q;
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            len_q       <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
            src_addr_q  <= '0;
            imem_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            len_q       <= len_d;
            words_q     <= words_d;
            err_q       <= err_d;
            src_addr_q  <= src_addr_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign src_rd     = (state_q == S_READ);
    assign imem_we    = (state_q == S_WRITE);
    assign imem_wdata = imem_we ? src_data : '0;
    assign busy       = (state_q == S_CHECK) || (state_q == S_READ) ||
                        (state_q == S_WAIT)  || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign err        = done && err_q;
    assign src_addr   = src_addr_q;
    assign imem_addr  = imem_addr_q;
    assign words_done = words_q;

endmodule
